// File: rtl/cpu_eu_pkg.sv
// Shared types and constants for the CPU execution unit.
package cpu_eu_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/decoder5to32.sv
// One-hot decoder for the register-file write address, gated by an enable.
// An unknown address matches no output, so the result stays all-zero.
module decoder5to32
    import cpu_eu_pkg::*;
(
    input  logic                en,
    input  reg_addr_t           addr,
    output logic [NUM_REGS-1:0] onehot
);

    // Compare against every index; an X compare is not true, so nothing fires.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en && (addr == reg_addr_t'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// Register file with one write port and two combinational read ports.
// $0 is hardwired to zero. Optional same-cycle write-through forwarding
// is enabled by defining RF_BYPASS_EN; otherwise reads see the pre-write value.
module reg_file_wb
    import cpu_eu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  reg_addr_t   WriteAddr,
    input  word_t       WriteData,
    input  reg_addr_t   ReadAddr1,
    input  reg_addr_t   ReadAddr2,
    output word_t       ReadData1,
    output word_t       ReadData2,
    output logic        WriteAck,
    output logic [15:0] WriteCount
);

    logic [NUM_REGS-1:0] dec_en;
    logic [NUM_REGS-1:0] wr_en;
    word_t               regs [NUM_REGS];

    decoder5to32 u_dec (
        .en     (RegWrite),
        .addr   (WriteAddr),
        .onehot (dec_en)
    );

    // Bit 0 forced low so $0 can never be written.
    assign wr_en = {dec_en[NUM_REGS-1:1], 1'b0};

    // Register array: per-register enable from the decoder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= WriteData;
                end
            end
        end
    end

    // Retirement tracking: writes to $0 still count as retired.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            WriteAck   <= 1'b0;
            WriteCount <= 16'h0000;
        end else begin
            WriteAck <= RegWrite;
            if (RegWrite) begin
                WriteCount <= WriteCount + 16'h0001;
            end
        end
    end

    // Read ports: $0 reads zero; optional forward of the in-flight write.
    always_comb begin
        ReadData1 = (ReadAddr1 == ZERO_REG) ? '0 : regs[ReadAddr1];
        ReadData2 = (ReadAddr2 == ZERO_REG) ? '0 : regs[ReadAddr2];
`ifdef RF_BYPASS_EN
        if (RegWrite && (WriteAddr != ZERO_REG)) begin
            if (ReadAddr1 == WriteAddr) begin
                ReadData1 = WriteData;
            end
            if (ReadAddr2 == WriteAddr) begin
                ReadData2 = WriteData;
            end
        end
`endif
    end

endmodule
